// File: rtl/rst_seq_const.sv
// Reset-release sequencer: NCH constant-valued flops leave RST_VAL one channel at a time,
// STEP counted edges apart, and settle at REL_VAL with 'done' raised alongside the last channel.
module rst_seq_const #(
    parameter int unsigned      NCH     = 4,
    parameter int unsigned      STEP    = 16,
    parameter logic [NCH-1:0]   RST_VAL = 4'b0010,
    parameter logic [NCH-1:0]   REL_VAL = 4'b1011
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           hold,
    input  logic           rearm,
    output logic [NCH-1:0] q,
    output logic           done
);

    localparam int unsigned LAST_EDGE = STEP * NCH;
    localparam int unsigned CNT_W     = $clog2(LAST_EDGE + 1);

    // One-hot style encoding leaves spare codes that the default branch steers back to SEQ.
    typedef enum logic [1:0] {
        ST_SEQ  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               done_q, done_d;
    logic               advance;
    logic               restart;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        advance = 1'b0;
        restart = 1'b0;
        case (state_q)
            ST_SEQ: begin
                if (!hold) begin
                    advance = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CNT_W'(LAST_EDGE)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // The counter saturates here; only rearm leaves this state.
                if (rearm) begin
                    restart = 1'b1;
                    state_d = ST_SEQ;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                restart = 1'b1;
                state_d = ST_SEQ;
                cnt_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SEQ;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Channels whose reset and release bits agree never move, so they are tied off outright.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        if (RST_VAL[i] == REL_VAL[i]) begin : g_const
            assign q[i] = RST_VAL[i];
        end else begin : g_flop
            localparam int unsigned REL_EDGE = STEP * (i + 1);
            logic chan_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    chan_q <= RST_VAL[i];
                end else if (restart) begin
                    chan_q <= RST_VAL[i];
                end else if (advance && (cnt_inc == CNT_W'(REL_EDGE))) begin
                    chan_q <= REL_VAL[i];
                end
            end

            assign q[i] = chan_q;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_rst_seq_const.sv
// Randomised self-checking bench for rst_seq_const against an edge-count reference model.
module tb_rst_seq_const;

    localparam int unsigned NCH  = 4;
    localparam int unsigned STEP = 16;
    localparam logic [3:0]  RST  = 4'b0010;
    localparam logic [3:0]  REL  = 4'b1011;
    localparam int          LAST = STEP * NCH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic       rearm = 1'b0;
    logic [3:0] q;
    logic       done;

    int nCompared = 0;
    int nMismatched = 0;

    // Number of un-held edges counted since the last reset or rearm.
    int effN = 0;

    rst_seq_const #(
        .NCH(NCH), .STEP(STEP), .RST_VAL(RST), .REL_VAL(REL)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold), .rearm(rearm), .q(q), .done(done)
    );

    always #10 clk = ~clk;

    function automatic logic [3:0] expQ(input int n);
        logic [3:0] v;
        for (int i = 0; i < NCH; i++)
            v[i] = (n >= STEP * (i + 1)) ? REL[i] : RST[i];
        return v;
    endfunction

    function automatic logic expDone(input int n);
        return (n >= LAST);
    endfunction

    task automatic tick(input logic h, input logic r);
        hold  = h;
        rearm = r;
        @(posedge clk);
        if (effN >= LAST) begin
            if (r) effN = 0;
        end else if (!h) begin
            effN++;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        hold  = 1'b0;
        rearm = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        effN  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            nCompared++;
            if (q !== RST || done !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL reset_hold t=%0t q=%b done=%b expected q=%b done=0", $time, q, done, RST);
            end
            #10;
        end
        @(negedge clk);
        reset = 1'b0;
        effN  = 0;
    endtask

    task automatic test_sequence();
        doReset();
        for (int e = 1; e <= LAST + 200; e++) begin
            tick(1'b0, 1'b0);
            nCompared++;
            if (q !== expQ(effN) || done !== expDone(effN)) begin
                nMismatched++;
                $display("[TB] FAIL seq edge=%0d q=%b done=%b expected q=%b done=%b", e, q, done, expQ(effN), expDone(effN));
            end
            if (e == 15 || e == 16 || e == 63 || e == 64) begin
                nCompared++;
                if ((e == 15 && (q !== 4'b0010 || done !== 1'b0)) ||
                    (e == 16 && (q !== 4'b0011 || done !== 1'b0)) ||
                    (e == 63 && (q !== 4'b0011 || done !== 1'b0)) ||
                    (e == 64 && (q !== 4'b1011 || done !== 1'b1))) begin
                    nMismatched++;
                    $display("[TB] FAIL seq_milestone edge=%0d q=%b done=%b", e, q, done);
                end
            end
        end
    endtask

    task automatic test_hold();
        doReset();
        for (int e = 1; e <= 90; e++) begin
            tick(e >= 10 && e <= 19, 1'b0);
            nCompared++;
            if (q !== expQ(effN) || done !== expDone(effN)) begin
                nMismatched++;
                $display("[TB] FAIL hold edge=%0d q=%b done=%b expected q=%b done=%b", e, q, done, expQ(effN), expDone(effN));
            end
            if (e == 25 || e == 26 || e == 73 || e == 74) begin
                nCompared++;
                if ((e == 25 && q !== 4'b0010) ||
                    (e == 26 && q !== 4'b0011) ||
                    (e == 73 && done !== 1'b0) ||
                    (e == 74 && (q !== 4'b1011 || done !== 1'b1))) begin
                    nMismatched++;
                    $display("[TB] FAIL hold_milestone edge=%0d q=%b done=%b", e, q, done);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        doReset();
        for (int e = 1; e <= 40; e++) tick(1'b0, 1'b0);
        #4;
        reset = 1'b1;
        #1;
        nCompared++;
        if (q !== RST || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset q=%b done=%b expected q=%b done=0", q, done, RST);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        effN  = 0;
        for (int e = 1; e <= LAST + 4; e++) begin
            tick(1'b0, 1'b0);
            nCompared++;
            if (q !== expQ(effN) || done !== expDone(effN)) begin
                nMismatched++;
                $display("[TB] FAIL async_resume edge=%0d q=%b done=%b expected q=%b done=%b", e, q, done, expQ(effN), expDone(effN));
            end
        end
    endtask

    task automatic test_rearm();
        doReset();
        for (int e = 1; e <= 140; e++) begin
            tick(1'b0, e == 20 || e == 70);
            nCompared++;
            if (q !== expQ(effN) || done !== expDone(effN)) begin
                nMismatched++;
                $display("[TB] FAIL rearm edge=%0d q=%b done=%b expected q=%b done=%b", e, q, done, expQ(effN), expDone(effN));
            end
            if (e == 64 || e == 70 || e == 86 || e == 133 || e == 134) begin
                nCompared++;
                if ((e == 64 && done !== 1'b1) ||
                    (e == 70 && (q !== 4'b0010 || done !== 1'b0)) ||
                    (e == 86 && q !== 4'b0011) ||
                    (e == 133 && done !== 1'b0) ||
                    (e == 134 && (q !== 4'b1011 || done !== 1'b1))) begin
                    nMismatched++;
                    $display("[TB] FAIL rearm_milestone edge=%0d q=%b done=%b", e, q, done);
                end
            end
        end
    endtask

    task automatic test_rearm_hold();
        doReset();
        for (int e = 1; e <= LAST + 3; e++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        nCompared++;
        if (q !== 4'b0010 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rearm_hold q=%b done=%b expected q=0010 done=0", q, done);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        nCompared++;
        if (q !== expQ(effN) || done !== expDone(effN) || effN != 1) begin
            nMismatched++;
            $display("[TB] FAIL rearm_hold_resume q=%b done=%b expected q=%b done=%b", q, done, expQ(effN), expDone(effN));
        end
    endtask

    task automatic test_random();
        logic h, r;
        doReset();
        for (int e = 1; e <= 3000; e++) begin
            h = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 15) == 0);
            tick(h, r);
            nCompared++;
            if (q !== expQ(effN) || done !== expDone(effN) || q[2:1] !== 2'b01) begin
                nMismatched++;
                $display("[TB] FAIL random edge=%0d h=%b r=%b q=%b done=%b expected q=%b done=%b", e, h, r, q, done, expQ(effN), expDone(effN));
            end
            if ($urandom_range(0, 299) == 0) begin
                #($urandom_range(2, 7));
                reset = 1'b1;
                #1;
                nCompared++;
                if (q !== RST || done !== 1'b0) begin
                    nMismatched++;
                    $display("[TB] FAIL random_reset edge=%0d q=%b done=%b", e, q, done);
                end
                @(negedge clk);
                reset = 1'b0;
                effN  = 0;
            end
        end
    endtask

    task automatic test_reset_toggle();
        fork
            begin
                reset = ~reset;
                #1547 reset = ~reset;
            end
            begin
                for (int k = 0; k < 428; k++) begin
                    #7;
                    nCompared++;
                    if (q[2:1] !== 2'b01) begin
                        nMismatched++;
                        $display("[TB] FAIL const_channels t=%0t q=%b expected q[2:1]=01", $time, q);
                    end
                end
            end
        join
        doReset();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_async_reset();
        test_rearm();
        test_rearm_hold();
        test_random();
        test_reset_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/rst_seq_const.md
Name: rst_seq_const

Overview:
Parametrised reset-release sequencer built from constant-valued flops with asynchronous reset. It drives NCH outputs that sit at RST_VAL during reset and step one channel at a time to REL_VAL after reset release, spaced STEP cycles apart. Any channel whose RST_VAL and REL_VAL bits are equal is a pure constant flop and must synthesise to a tie-off under sequential optimisation. The block sits in the clock/reset domain logic and provides staggered enables to downstream blocks; it also serves as the sequential-optimisation check vehicle for multi-channel constant flops.

Parameters:
NCH, 4, number of output channels (>=1)
STEP, 16, clock edges between successive channel releases (>=1)
RST_VAL, 4'b0010, NCH-bit value of q while reset is high and after rearm
REL_VAL, 4'b1011, NCH-bit final value of q once the sequence completes
CNT_W, derived localparam = clog2(STEP*NCH+1), width of the internal edge counter

Ports:
clk    input   1    rising-edge clock
reset  input   1    asynchronous, active-high reset
hold   input   1    synchronous pause; while high in SEQ, the counter and q are frozen
rearm  input   1    synchronous restart request; honoured only in DONE
q      output  NCH  channel outputs
done   output  1    high once every channel holds its REL_VAL bit

Behaviour:
- Reset (async, active-high): q=RST_VAL, done=0, cnt=0, state=SEQ, all applied immediately with no clock edge needed. Reset dominates every other input.
- States: SEQ (counting), DONE (terminal). No other states; unreachable encodings recover to SEQ with cnt=0.
- SEQ: at each rising edge with hold=0, cnt increments by 1. The first edge after reset deasserts is cnt=1.
  - Channel i (0..NCH-1) loads REL_VAL[i] on the edge where cnt becomes STEP*(i+1). Once loaded it never changes until reset or rearm.
  - Channels with RST_VAL[i]==REL_VAL[i] show no visible transition at their release edge.
- DONE entry: on the edge where cnt becomes STEP*NCH, the same edge as the last channel load, state<=DONE and done<=1 together.
- hold=1 in SEQ: cnt, q, and state hold their values; release edges shift later by the number of held edges. hold is ignored in DONE.
- rearm:
  - In DONE, rearm=1 at an edge sets q<=RST_VAL, done<=0, cnt<=0, state<=SEQ. The next hold=0 edge counts as cnt=1.
  - In SEQ, rearm is ignored.
  - If rearm=1 and hold=1 in DONE, rearm wins.
- Reset mid-sequence: q returns to RST_VAL asynchronously and the count restarts from 0 on release. Partial progress is lost.
- Reset deassertion asynchronous to clk: the first edge at which reset is sampled low is edge 1. The bench must not check sub-cycle alignment.
- cnt never exceeds STEP*NCH. No wrap-around is allowed; cnt saturates in DONE.
- Outputs are registered only, with no combinational path from hold or rearm to q or done.

Test Plan:
(Defaults: NCH=4, STEP=16, RST_VAL=0010, REL_VAL=1011, clk period 20 ns.)
1. Hold reset high for 100 ns -> q=4'b0010 and done=0 throughout, with no clk dependence.
2. Release reset, hold=0 -> q=0011 at edge 16; q stays 0011 at edges 32 and 48 (ch1 and ch2 are constants); q=1011 and done=1 at edge 64; both stay stable for 200 more edges.
3. Release, then hold=1 for edges 10..19 (10 edges) -> ch0 loads at edge 26; q=1011 and done=1 at edge 74.
4. Assert reset asynchronously mid-cycle between edges 40 and 41 -> q=0010 and done=0 immediately. Release again -> sequence repeats exactly as in scenario 2, counted from the new release.
5. rearm pulse at edge 20 (SEQ) -> ignored, done still rises at edge 64. rearm pulse at edge 70 (DONE) -> at edge 70 q=0010 and done=0; q=0011 at edge 86; done=1 at edge 134.
6. In DONE, hold=1 and rearm=1 on the same edge -> rearm honoured: q=0010, done=0. Then toggle reset every 1547 ns for 3000 ns -> q[1]==1 and q[2]==0 at all times. Synthesis netlist contains no flops for ch1 or ch2.
